// File: rtl/warpv_ctrl_pkg.sv
// Shared types and constants for the warpv boot/run sequencer.
package warpv_ctrl_pkg;

   localparam int INSTR_W = 32;
   localparam int LANE_W  = 8;
   localparam int LANES   = INSTR_W / LANE_W;

   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_load  = 3'd1,
      st_ready = 3'd2,
      st_run   = 3'd3,
      st_pass  = 3'd4,
      st_fail  = 3'd5
   } state_t;

   // Loader is only held off while a loaded image waits for start or the core runs.
   function automatic logic ld_open(input state_t s);
      return (s == st_idle) || (s == st_load) || (s == st_pass) || (s == st_fail);
   endfunction

endpackage

// File: rtl/warpv_ld_packer.sv
// Packs loader bytes little-endian into instruction words, zero-padding a short final word.
// Latency: word_vld one cycle after the completing byte. Backpressure: none, caller gates byte_vld.
module warpv_ld_packer
   import warpv_ctrl_pkg::*;
#(
   parameter int WORD_W = INSTR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_vld,
   input  logic [7:0]        byte_dat,
   input  logic              byte_last,
   output logic              word_done,
   output logic              word_vld,
   output logic [WORD_W-1:0] word_dat
);

   localparam int NL  = WORD_W / LANE_W;
   localparam int LCW = $clog2(NL);

   logic [NL-1:0][LANE_W-1:0] lanes_q;
   logic [NL-1:0][LANE_W-1:0] word_c;
   logic [LCW-1:0]            lane_q;

   // Lanes below the counter hold earlier bytes; the current byte lands at the counter; the rest are zero.
   always_comb begin
      word_c = '0;
      for (int i = 0; i < NL; i++) begin
         if (LCW'(i) < lane_q)
            word_c[i] = lanes_q[i];
         else if (LCW'(i) == lane_q)
            word_c[i] = byte_dat;
      end
   end

   assign word_done = byte_vld & (byte_last | (lane_q == LCW'(NL - 1)));

   always_ff @(posedge clk) begin
      if (!reset) begin
         lanes_q  <= '0;
         lane_q   <= '0;
         word_vld <= 1'b0;
         word_dat <= '0;
      end else begin
         word_vld <= word_done;
         if (byte_vld) begin
            if (word_done) begin
               lane_q   <= '0;
               word_dat <= word_c;
            end else begin
               lanes_q[lane_q] <= byte_dat;
               lane_q          <= lane_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/warpv_run_ctrl.sv
// Boot/run sequencer: loads imem from a byte stream, holds/releases core reset, watchdog, status led.
// Latency: all outputs registered, one cycle after the deciding input. Backpressure: ld_ready low in READY/RUN.
module warpv_run_ctrl
   import warpv_ctrl_pkg::*;
#(
   parameter int IMEM_AW     = 6,
   parameter int INSTR_W     = 32,
   parameter int WDOG_CYCLES = 2000,
   parameter int BLINK_DIV   = 50
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ld_valid,
   input  logic [7:0]         ld_data,
   input  logic               ld_last,
   output logic               ld_ready,
   input  logic               start,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_reset,
   input  logic               core_halt,
   input  logic               core_pass,
   output logic               led,
   output logic [2:0]         state_o
);

   localparam int WDW = $clog2(WDOG_CYCLES) + 1;
   localparam int BCW = $clog2(BLINK_DIV) + 1;

   state_t           state_q, state_n;
   logic [IMEM_AW:0] waddr_q, waddr_n, base;
   logic [WDW-1:0]   wdog_q;
   logic [BCW-1:0]   blink_q;
   logic             acc, new_img, overflow, feed, word_done;

   warpv_ld_packer #(
      .WORD_W (INSTR_W)
   ) u_packer (
      .clk       (clk),
      .reset     (reset),
      .byte_vld  (feed),
      .byte_dat  (ld_data),
      .byte_last (ld_last),
      .word_done (word_done),
      .word_vld  (imem_we),
      .word_dat  (imem_wdata)
   );

   // waddr carries one extra bit so a full memory is distinguishable from an empty one.
   always_comb begin
      state_n  = state_q;
      acc      = ld_valid & ld_ready;
      new_img  = (state_q == st_idle) || (state_q == st_pass) || (state_q == st_fail);
      overflow = (state_q == st_load) & waddr_q[IMEM_AW];
      feed     = acc & ~overflow;
      base     = new_img ? '0 : waddr_q;
      waddr_n  = waddr_q;
      if (feed)
         waddr_n = word_done ? base + 1'b1 : base;

      case (state_q)
         st_idle, st_pass, st_fail: begin
            if (acc)
               state_n = ld_last ? st_ready : st_load;
            else if (start)
               state_n = st_run;
         end
         st_load: begin
            if (acc) begin
               if (overflow)
                  state_n = st_fail;
               else if (ld_last)
                  state_n = st_ready;
            end
         end
         st_ready: begin
            if (start)
               state_n = st_run;
         end
         st_run: begin
            if (core_halt)
               state_n = core_pass ? st_pass : st_fail;
            else if (wdog_q == WDW'(WDOG_CYCLES - 1))
               state_n = st_fail;
         end
         default: state_n = st_idle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= st_idle;
         ld_ready   <= 1'b1;
         core_reset <= 1'b1;
         imem_addr  <= '0;
         waddr_q    <= '0;
         wdog_q     <= '0;
         blink_q    <= '0;
         led        <= 1'b0;
      end else begin
         state_q    <= state_n;
         ld_ready   <= ld_open(state_n);
         core_reset <= (state_n != st_run);
         waddr_q    <= waddr_n;
         imem_addr  <= (feed & word_done) ? base[IMEM_AW-1:0] : waddr_n[IMEM_AW-1:0];
         wdog_q     <= (state_q == st_run && state_n == st_run) ? wdog_q + 1'b1 : '0;

         // FAIL lights the led on entry, then inverts it every BLINK_DIV cycles.
         if (state_n == st_fail) begin
            if (state_q != st_fail) begin
               led     <= 1'b1;
               blink_q <= '0;
            end else if (blink_q == BCW'(BLINK_DIV - 1)) begin
               led     <= ~led;
               blink_q <= '0;
            end else begin
               blink_q <= blink_q + 1'b1;
            end
         end else begin
            led     <= (state_n == st_pass);
            blink_q <= '0;
         end
      end
   end

   assign state_o = state_q;

endmodule

// File: tb/tb_warpv_run_ctrl.sv
// Directed bench: imem writes checked by a queue-based scoreboard, control outputs checked inline.
module tb_warpv_run_ctrl;

   localparam int AW = 6;
   localparam int BD = 4;
   localparam int WD = 20;

   logic          clk = 1'b0;
   logic          reset, ld_valid, ld_last, start, core_halt, core_pass;
   logic [7:0]    ld_data;
   logic          ld_ready, imem_we, core_reset, led;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [2:0]    state_o;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   warpv_run_ctrl #(
      .IMEM_AW     (AW),
      .INSTR_W     (32),
      .WDOG_CYCLES (WD),
      .BLINK_DIV   (BD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ld_valid   (ld_valid),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .ld_ready   (ld_ready),
      .start      (start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .core_halt  (core_halt),
      .core_pass  (core_pass),
      .led        (led),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      logic ok;
      ok       = 1'b0;
      ld_valid = 1'b1;
      ld_data  = b;
      ld_last  = last;
      for (int i = 0; i < 50; i++) begin
         ok = (ld_ready === 1'b1);
         @(posedge clk);
         #1;
         if (ok) break;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      chk("ld_accept", {31'd0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      ld_valid  = 1'b0;
      ld_last   = 1'b0;
      ld_data   = 8'h00;
      start     = 1'b0;
      core_halt = 1'b0;
      core_pass = 1'b0;
      step(2);
      reset = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state_o, 0);
      chk({tag, "_ld_ready"}, ld_ready, 1);
      chk({tag, "_core_reset"}, core_reset, 1);
      chk({tag, "_led"}, led, 0);
      chk({tag, "_imem_we"}, imem_we, 0);
      chk({tag, "_imem_addr"}, imem_addr, 0);
      chk({tag, "_imem_wdata"}, imem_wdata, 0);
   endtask

   // Scoreboard monitor: every imem write must match the oldest expected write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr %0h data %0h expected none", imem_addr, imem_wdata);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_addr", imem_addr, w.a);
            chk("wr_data", imem_wdata, w.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset values
      do_reset();
      chk_reset_vals("rst");

      // 1: two full words
      push(0, 32'h04030201);
      push(1, 32'h08070605);
      for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
      chk("t1_state", state_o, 2);
      chk("t1_ld_ready", ld_ready, 0);
      chk("t1_core_reset", core_reset, 1);
      step(2);

      // 2: short final word zero-padded, then start
      do_reset();
      push(0, 32'h04030201);
      push(1, 32'h00000005);
      for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
      chk("t2_state", state_o, 2);
      step(2);
      pulse_start();
      chk("t2_state_run", state_o, 3);
      chk("t2_core_reset", core_reset, 0);
      chk("t2_led", led, 0);

      // 3: halt with pass at cycle 10 of RUN
      step(9);
      chk("t3_still_run", state_o, 3);
      core_halt = 1'b1;
      core_pass = 1'b1;
      step(1);
      core_halt = 1'b0;
      core_pass = 1'b0;
      chk("t3_state", state_o, 4);
      chk("t3_led", led, 1);
      chk("t3_core_reset", core_reset, 1);
      chk("t3_ld_ready", ld_ready, 1);
      step(5);
      chk("t3_led_steady", led, 1);

      // 4: rerun from PASS, watchdog expiry, blink
      pulse_start();
      chk("t4_run", state_o, 3);
      step(WD - 1);
      chk("t4_run_last", state_o, 3);
      chk("t4_core_reset_run", core_reset, 0);
      step(1);
      chk("t4_fail", state_o, 5);
      chk("t4_core_reset", core_reset, 1);
      chk("t4_led0", led, 1);
      step(BD - 1);
      chk("t4_led_hold", led, 1);
      step(1);
      chk("t4_led_toggle", led, 0);
      step(BD);
      chk("t4_led_toggle2", led, 1);

      // 5: halt on the expiry cycle wins
      pulse_start();
      step(WD - 1);
      core_halt = 1'b1;
      core_pass = 1'b1;
      step(1);
      core_halt = 1'b0;
      core_pass = 1'b0;
      chk("t5_halt_wins", state_o, 4);
      pulse_start();
      step(3);
      core_halt = 1'b1;
      step(1);
      core_halt = 1'b0;
      chk("t5_halt_nopass", state_o, 5);

      // 5b: byte and start together in IDLE -> LOAD only
      do_reset();
      start    = 1'b1;
      ld_valid = 1'b1;
      ld_data  = 8'hAA;
      step(1);
      start    = 1'b0;
      ld_valid = 1'b0;
      chk("t5_byte_wins", state_o, 1);
      chk("t5_core_reset", core_reset, 1);

      // 6: reset mid-word discards the partial byte
      reset = 1'b0;
      step(1);
      chk_reset_vals("t6w");
      reset = 1'b1;
      push(0, 32'h14131211);
      for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i), 1'b0);
      step(2);

      // 6: reset mid-RUN
      do_reset();
      pulse_start();
      chk("t6_run", state_o, 3);
      chk("t6_run_core_reset", core_reset, 0);
      step(3);
      reset = 1'b0;
      step(1);
      chk_reset_vals("t6r");
      reset = 1'b1;

      // Overflow: 64 full words, then one more byte
      for (int w = 0; w < 64; w++)
         push(6'(w), {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0);
      chk("ov_full_state", state_o, 1);
      send_byte(8'hEE, 1'b0);
      chk("ov_state", state_o, 5);
      step(3);

      chk("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
